// File: rtl/diff_pkg.sv
// Shared definitions for the differential decoder: FSM state encoding and
// default widths for the running-sum word and the legal increment.
package diff_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_INC_W  = 4;

  // EMPTY: no reference sample held; PRIMED: prev register holds a reference.
  typedef enum logic {
    EMPTY  = 1'b0,
    PRIMED = 1'b1
  } state_e;

endpackage

// File: rtl/diff_decoder_if.sv
// Stream bus of the differential decoder: running-sum input channel and
// recovered-increment output channel, both valid/ready.
// The slave modport is the decoder's view; master is the surrounding logic.
interface diff_decoder_if import diff_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_sum;
  logic              in_first;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_delta;
  logic              out_ovf;
  logic [DATA_W-1:0] out_count;

  modport slave (
    input  in_valid, in_sum, in_first, out_ready,
    output in_ready, out_valid, out_delta, out_ovf, out_count
  );

  modport master (
    output in_valid, in_sum, in_first, out_ready,
    input  in_ready, out_valid, out_delta, out_ovf, out_count
  );

endinterface

// File: rtl/diff_out_reg.sv
// One-deep valid/ready output register holding the recovered delta and its
// overflow flag, plus a wrapping count of delivered results.
module diff_out_reg import diff_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] delta_i,
  input  logic              ovf_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] delta_o,
  output logic              ovf_o,
  output logic [DATA_W-1:0] count_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] delta_q, delta_d;
  logic              ovf_q,   ovf_d;
  logic [DATA_W-1:0] count_q, count_d;

  // Next-state: a delivered result clears valid, a new load (which may land in
  // the same cycle) sets it again so back-to-back traffic has no bubble.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // (which would infer a latch); blocking '=' is right in combinational code.
    valid_d = valid_q;
    delta_d = delta_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
      count_d = count_q + DATA_W'(1);
    end
    if (load_i) begin
      valid_d = 1'b1;
      delta_d = delta_i;
      ovf_d   = ovf_i;
    end
  end

  // Output register state.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the data register is reset too, so out_delta reads 0 after reset
    // instead of stale content; sequential state uses non-blocking '<='.
    if (!rst_n) begin
      valid_q <= 1'b0;
      delta_q <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      delta_q <= delta_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  assign valid_o = valid_q;
  assign delta_o = delta_q;
  assign ovf_o   = ovf_q;
  assign count_o = count_q;

endmodule

// File: rtl/diff_decoder.sv
// Differential decoder: recovers per-sample increments from a running-sum
// stream by subtracting the previous sample (or 0 at a frame start).
// Optional feature: define DIFF_DECODER_SAT_EN to clamp out-of-range deltas
// to the largest legal increment; otherwise the raw wrapped difference is kept.
module diff_decoder import diff_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int INC_W  = DEF_INC_W
) (
  input logic           clk,
  input logic           rst_n,
  diff_decoder_if.slave bus
);

  localparam logic [DATA_W-1:0] MAX_INC = DATA_W'((1 << INC_W) - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] prev_q,  prev_d;
  logic              in_fire;
  logic [DATA_W-1:0] base;
  logic [DATA_W-1:0] raw_delta;
  logic              ovf;
  logic [DATA_W-1:0] delta_res;

  // Accept whenever the output register is free or being drained this cycle.
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign in_fire      = bus.in_valid && bus.in_ready;

  // Subtractor and FSM: frame starts and the EMPTY state decode against 0.
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    base      = (state_q == EMPTY || bus.in_first) ? '0 : prev_q;
    raw_delta = bus.in_sum - base;
    ovf       = raw_delta > MAX_INC;
`ifdef DIFF_DECODER_SAT_EN
    delta_res = ovf ? MAX_INC : raw_delta;
`else
    delta_res = raw_delta;
`endif
    if (in_fire) begin
      state_d = PRIMED;
      prev_d  = bus.in_sum;
    end
  end

  // Reference state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
    end
  end

  diff_out_reg #(.DATA_W(DATA_W)) u_out_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (in_fire),
    .delta_i (delta_res),
    .ovf_i   (ovf),
    .ready_i (bus.out_ready),
    .valid_o (bus.out_valid),
    .delta_o (bus.out_delta),
    .ovf_o   (bus.out_ovf),
    .count_o (bus.out_count)
  );

endmodule
